pool_unit: RTL and testbench
============================

POOL_UNIT -- requirements
Module: pool_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed two's-complement element width.
REQ-002 SHALL have parameter CH, default 4: parallel channel lanes per beat.
REQ-003 SHALL have parameter CNT_W, default 16: width of op_num and the element counter.
REQ-004 SHALL have parameter RECIP_W, default 16: width of the unsigned Q0.RECIP_W reciprocal.
REQ-005 SHALL have port clk, input, 1: the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: opens a window; sampled only in IDLE.
REQ-008 SHALL have port mode, input, 1: 0 = max pool, 1 = average pool; latched with start.
REQ-009 SHALL have port op_num, input, CNT_W: elements per window; latched with start.
REQ-010 SHALL have port recip, input, RECIP_W: 1/op_num in Q0.RECIP_W; latched with start.
REQ-011 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, CH*DATA_W): input beat handshake; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, CH*DATA_W): result handshake, same lane packing.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ACC, SCALE and DONE.
REQ-015 SHALL go IDLE->ACC on start; op_num=0 SHALL be latched as 1.
REQ-016 SHALL drive in_ready=1 only in ACC; a beat is accepted when in_valid&&in_ready.
REQ-017 Max mode: the first accepted beat SHALL load each lane register; later beats SHALL keep the signed maximum per lane.
REQ-018 Avg mode: each lane SHALL accumulate the sign-extended element into an ACC_W=DATA_W+CNT_W signed accumulator cleared on start; ACC_W SHALL NOT wrap for any legal op_num.
REQ-019 Accepting the op_num-th beat SHALL move ACC->DONE (max) or ACC->SCALE (avg) on the next edge; no further beat SHALL be accepted in that window.
REQ-020 SCALE SHALL last exactly one cycle: lane = (acc*recip + 2^(RECIP_W-1)) >>> RECIP_W, saturated to the DATA_W signed range; then ->DONE.
REQ-021 DONE SHALL hold out_valid=1 and stable out_data until out_ready=1; the handshake cycle SHALL return to IDLE.
REQ-022 Latency from last accepted beat to out_valid SHALL be 1 cycle (max) or 2 cycles (avg).
REQ-023 start while not IDLE SHALL be ignored; start and a handshake completing in DONE in the same cycle SHALL NOT open a window (one IDLE cycle minimum).
REQ-024 in_valid=0 gaps in ACC SHALL stall without changing state or count.

Reset
REQ-025 rst SHALL force IDLE, out_valid=0, in_ready=0, busy=0, out_data=0 and clear counters and lane registers.
REQ-026 rst mid-window SHALL discard partial results; no out_valid SHALL follow.

Configuration
REQ-027 With POOL_AVG_EN defined, both modes and the SCALE state SHALL exist.
REQ-028 Without POOL_AVG_EN, mode and recip SHALL be ignored, every window SHALL be max pool, and no accumulator or multiplier SHALL be synthesised.

Structure
REQ-029 Shared package pool_pkg SHALL hold the state encoding, the mode encodings (POOL_MAX=0, POOL_AVG=1) and the ACC_W derivation function.
REQ-030 Per-lane datapath SHALL be sub-module pool_lane (max/accumulate/scale/saturate), instantiated CH times; control FSM and counter stay in pool_unit.

Verification (DATA_W=16, CH=4, RECIP_W=16)
REQ-031 Max, op_num=4, lane0 beats 3,-7,9,2 -> lane0 out=9, out_valid 1 cycle after 4th beat.
REQ-032 Avg, op_num=4, recip=0x4000, lane1 beats 10,20,30,41 -> lane1 out=25 (25.25 rounded), out_valid 2 cycles after 4th beat.
REQ-033 Avg, op_num=2, recip=0x8000, lanes 32767,32767 -> 32767; lanes -32768,-32768 -> -32768 (saturate bounds).
REQ-034 out_ready low 5 cycles in DONE -> out_data stable, in_ready=0, start ignored; handshake -> IDLE next edge.
REQ-035 rst asserted after 2 of 4 beats -> IDLE next edge, all outputs 0, no out_valid; fresh window then returns correct result.
REQ-036 op_num=0 with single beat -5 in max mode -> out=-5; without POOL_AVG_EN, mode=1 -> max result returned.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling unit: FSM state encoding, pooling
// mode encodings and the accumulator width derivation.
package pool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } pool_state_t;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    // Accumulator width: enough headroom to sum 2^cnt_w - 1 elements of
    // data_w bits without wrapping.
    function automatic int acc_width(input int data_w, input int cnt_w);
        return data_w + cnt_w;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel lane of the pooling datapath: running signed maximum, and
// (when POOL_AVG_EN is defined) sign-extended accumulation followed by a
// single-cycle reciprocal multiply, round-half-up and saturation.
// Without POOL_AVG_EN only the max path exists; no accumulator or
// multiplier is built.
module pool_lane
    import pool_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16,
    parameter int RECIP_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               upd,
    input  logic               first,
    input  logic               scale,
    input  logic               mode,
    input  logic [RECIP_W-1:0] recip,
    input  logic [DATA_W-1:0]  din,
    output logic [DATA_W-1:0]  dout
);

    logic signed [DATA_W-1:0] din_s;
    logic signed [DATA_W-1:0] res_p0;

    assign din_s = $signed(din);
    assign dout  = res_p0;

`ifdef POOL_AVG_EN
    localparam int ACC_W = acc_width(DATA_W, CNT_W);
    localparam int PW    = ACC_W + RECIP_W + 1;

    localparam logic signed [PW-1:0]  HALF = PW'(1) << (RECIP_W - 1);
    localparam logic signed [ACC_W:0] SMAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SMIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc_p0;
    logic signed [PW-1:0]    prod;

    // Round half up, then drop the RECIP_W fractional bits (arithmetic shift).
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] t;
        t = p + HALF;
        return t[PW-1:RECIP_W];
    endfunction

    // Clamp to the signed DATA_W range.
    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W:0] v);
        logic signed [ACC_W:0] c;
        if (v > SMAX)
            c = SMAX;
        else if (v < SMIN)
            c = SMIN;
        else
            c = v;
        return c[DATA_W-1:0];
    endfunction

    // recip is unsigned Q0.RECIP_W, so it enters the signed product zero-extended.
    assign prod = PW'(acc_p0) * PW'($signed({1'b0, recip}));

    // Result register: running max in max mode, scaled average in SCALE.
    always_ff @(posedge clk) begin
        if (rst)
            res_p0 <= '0;
        else if (upd && (mode == POOL_MAX) && (first || (din_s > res_p0)))
            res_p0 <= din_s;
        else if (scale)
            res_p0 <= sat_data(round_shift(prod));
    end

    // Accumulator: cleared when a window opens, sums every accepted element.
    always_ff @(posedge clk) begin
        if (rst || clr)
            acc_p0 <= '0;
        else if (upd && (mode == POOL_AVG))
            acc_p0 <= acc_p0 + ACC_W'(din_s);
    end
`else
    logic unused_lane;
    assign unused_lane = (^{clr, scale, mode, recip}) ^ (CNT_W == 0);

    // Result register: first beat loads, later beats keep the signed maximum.
    always_ff @(posedge clk) begin
        if (rst)
            res_p0 <= '0;
        else if (upd && (first || (din_s > res_p0)))
            res_p0 <= din_s;
    end
`endif

endmodule

// File: rtl/pool_unit.sv
// Pooling unit top: window control FSM (IDLE/ACC/SCALE/DONE), beat counter
// and CH parallel pool_lane datapaths. Optional average pooling is enabled
// by defining POOL_AVG_EN; otherwise every window is max pool and
// mode/recip are ignored.
module pool_unit
    import pool_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CH      = 4,
    parameter int CNT_W   = 16,
    parameter int RECIP_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [CNT_W-1:0]     op_num,
    input  logic [RECIP_W-1:0]   recip,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DATA_W-1:0] out_data,
    output logic                 busy
);

    pool_state_t        state;
    logic               mode_r;
    logic [CNT_W-1:0]   num_r;
    logic [CNT_W-1:0]   cnt;
    logic [RECIP_W-1:0] recip_r;
    logic               accept;
    logic               first_beat;
    logic               last_beat;
    logic               clr;
    logic               scale_en;

    assign accept     = in_valid && in_ready;
    assign first_beat = (cnt == '0);
    assign last_beat  = ((cnt + CNT_W'(1)) == num_r);
    assign clr        = (state == ST_IDLE) && start;
    assign scale_en   = (state == ST_SCALE);

    // Control FSM with registered handshake/status outputs and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            num_r     <= '0;
            mode_r    <= POOL_MAX;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_ACC;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        num_r    <= (op_num == '0) ? CNT_W'(1) : op_num;
`ifdef POOL_AVG_EN
                        mode_r   <= mode;
`else
                        mode_r   <= POOL_MAX;
`endif
                    end
                end
                ST_ACC: begin
                    if (accept) begin
                        cnt <= cnt + CNT_W'(1);
                        if (last_beat) begin
                            in_ready <= 1'b0;
                            if (mode_r == POOL_AVG) begin
                                state <= ST_SCALE;
                            end else begin
                                state     <= ST_DONE;
                                out_valid <= 1'b1;
                            end
                        end
                    end
                end
                ST_SCALE: begin
                    state     <= ST_DONE;
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef POOL_AVG_EN
    // Reciprocal is captured when the window opens.
    always_ff @(posedge clk) begin
        if (rst)
            recip_r <= '0;
        else if (clr)
            recip_r <= recip;
    end
`else
    logic unused_cfg;
    assign recip_r    = '0;
    assign unused_cfg = ^{mode, recip};
`endif

    for (genvar k = 0; k < CH; k++) begin : g_lane
        pool_lane #(
            .DATA_W  (DATA_W),
            .CNT_W   (CNT_W),
            .RECIP_W (RECIP_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .upd   (accept),
            .first (first_beat),
            .scale (scale_en),
            .mode  (mode_r),
            .recip (recip_r),
            .din   (in_data[k*DATA_W +: DATA_W]),
            .dout  (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_pool_unit.sv
// Self-checking bench for pool_unit (DATA_W=16, CH=4, RECIP_W=16).
// Honours POOL_AVG_EN: without it, average requests are expected to
// return max-pool results with max-pool latency.
module tb_pool_unit;

    localparam int DATA_W  = 16;
    localparam int CH      = 4;
    localparam int CNT_W   = 16;
    localparam int RECIP_W = 16;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 mode;
    logic [CNT_W-1:0]     op_num;
    logic [RECIP_W-1:0]   recip;
    logic                 in_valid;
    logic                 in_ready;
    logic [CH*DATA_W-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH*DATA_W-1:0] out_data;
    logic                 busy;

    pool_unit #(
        .DATA_W  (DATA_W),
        .CH      (CH),
        .CNT_W   (CNT_W),
        .RECIP_W (RECIP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .op_num    (op_num),
        .recip     (recip),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [63:0] beat_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic int pick16();
        int sel;
        sel = $urandom_range(0, 5);
        if (sel == 0) return 32767;
        if (sel == 1) return -32768;
        return $urandom_range(0, 65535);
    endfunction

    function automatic logic eff_mode(input logic md);
`ifdef POOL_AVG_EN
        return md;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: max or rounded, saturated average of the beats in beat_q.
    function automatic logic [63:0] model(input logic md, input int rc);
        logic [63:0]        r;
        logic [63:0]        b;
        logic signed [15:0] e;
        longint             v, m, s, q;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            m = 0;
            s = 0;
            for (int i = 0; i < beat_q.size(); i++) begin
                b = beat_q[i];
                e = b[k*16 +: 16];
                v = longint'(e);
                if (i == 0 || v > m) m = v;
                s = s + v;
            end
            if (md) begin
                q = (s * longint'(rc) + 32768) >>> 16;
                if (q > 32767) q = 32767;
                if (q < -32768) q = -32768;
            end else begin
                q = m;
            end
            r[k*16 +: 16] = q[15:0];
        end
        return r;
    endfunction

    // One complete window: start, beats with random gaps, result, hold, handshake.
    task automatic run_window(input logic md, input int opn, input int rc, input int hold);
        int          n;
        int          lat;
        int          gaps;
        logic        em;
        logic [63:0] exp;
        n   = (opn == 0) ? 1 : opn;
        em  = eff_mode(md);
        exp = model(em, rc);
        start  = 1'b1;
        mode   = md;
        op_num = opn[15:0];
        recip  = rc[15:0];
        tick();
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_rdy", 64'(in_ready), 64'd1);
        for (int i = 0; i < n; i++) begin
            gaps = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                tick();
                chk("gap_rdy", 64'(in_ready), 64'd1);
                chk("gap_ov", 64'(out_valid), 64'd0);
            end
            chk("beat_rdy", 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_data  = beat_q[i];
            tick();
        end
        // Keep offering garbage: it must not be taken once the window is full.
        in_data = {$urandom, $urandom};
        lat = 1;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(lat), em ? 64'd2 : 64'd1);
        chk("done_rdy", 64'(in_ready), 64'd0);
        chk("data", out_data, exp);
        for (int i = 0; i < hold; i++) begin
            start = (i == 1);
            tick();
            chk("hold_ov", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, exp);
            chk("hold_rdy", 64'(in_ready), 64'd0);
            chk("hold_busy", 64'(busy), 64'd1);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        chk("hs_ov", 64'(out_valid), 64'd0);
        chk("hs_busy", 64'(busy), 64'd0);
        out_ready = 1'b0;
        start     = 1'b0;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_rdy", 64'(in_ready), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int opn, n, rc;
        logic md;
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        op_num    = '0;
        recip     = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", out_data, 64'd0);
        rst = 1'b0;
        tick();

        // Max pool, lane0 3,-7,9,2 -> 9; output held 5 cycles.
        beat_q = {};
        beat_q.push_back(pack(3, pick16(), pick16(), pick16()));
        beat_q.push_back(pack(-7, pick16(), pick16(), pick16()));
        beat_q.push_back(pack(9, pick16(), pick16(), pick16()));
        beat_q.push_back(pack(2, pick16(), pick16(), pick16()));
        run_window(1'b0, 4, 0, 5);

        // Average, lane1 10,20,30,41 with recip 1/4 -> 25.
        beat_q = {};
        beat_q.push_back(pack(pick16(), 10, pick16(), pick16()));
        beat_q.push_back(pack(pick16(), 20, pick16(), pick16()));
        beat_q.push_back(pack(pick16(), 30, pick16(), pick16()));
        beat_q.push_back(pack(pick16(), 41, pick16(), pick16()));
        run_window(1'b1, 4, 32'h4000, 1);

        // Average bounds: full-scale positive and negative.
        beat_q = {};
        beat_q.push_back(pack(32767, -32768, 32767, -32768));
        beat_q.push_back(pack(32767, -32768, 32767, -32768));
        run_window(1'b1, 2, 32'h8000, 0);

        // Oversized reciprocal drives the average into saturation.
        beat_q = {};
        beat_q.push_back(pack(32767, -32768, 100, -100));
        beat_q.push_back(pack(32767, -32768, 300, -300));
        run_window(1'b1, 2, 32'hFFFF, 0);

        // op_num = 0 behaves as a single-element window.
        beat_q = {};
        beat_q.push_back(pack(-5, pick16(), pick16(), pick16()));
        run_window(1'b0, 0, 0, 2);

        // Reset after two of four beats discards the window.
        start  = 1'b1;
        mode   = 1'b1;
        op_num = 16'd4;
        recip  = 16'h4000;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        tick();
        in_data  = {$urandom, $urandom};
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rdy", 64'(in_ready), 64'd0);
        chk("mid_rst_ov", 64'(out_valid), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_ov", 64'(out_valid), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
        end

        // Fresh window after reset.
        beat_q = {};
        for (int i = 0; i < 4; i++)
            beat_q.push_back(pack(pick16(), pick16(), pick16(), pick16()));
        run_window(1'b0, 4, 0, 1);

        // Randomized windows.
        for (int w = 0; w < 30; w++) begin
            md  = 1'($urandom_range(0, 1));
            opn = $urandom_range(0, 9);
            n   = (opn == 0) ? 1 : opn;
            if ($urandom_range(0, 3) == 0)
                rc = $urandom_range(0, 65535);
            else
                rc = (n == 1) ? 65535 : 65536 / n;
            beat_q = {};
            for (int i = 0; i < n; i++)
                beat_q.push_back(pack(pick16(), pick16(), pick16(), pick16()));
            run_window(md, opn, rc, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
